nibble_uart_tx: RTL and testbench

Serial transmitter that consumes the 4-bit nibble produced by the upstream register stage. It frames each nibble as start bit, 4 data bits LSB first, optional even-parity bit and stop bit, at a programmable bit period. A valid/ready handshake throttles the upstream stage so that no nibble is lost or duplicated.

---
 rtl/nibble_tx_pkg.sv | 9 +
 rtl/nibble_uart_tx_bit_timer.sv | 17 +
 rtl/nibble_uart_tx.sv | 85 ++++++++
 tb/tb_nibble_uart_tx.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/nibble_tx_pkg.sv
// nibble_tx_pkg: shared states, line levels and parity helper for the nibble transmitter
package nibble_tx_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;
  localparam logic TXD_IDLE  = 1'b1;
  localparam logic TXD_START = 1'b0;
  function automatic logic even_parity4(input logic [3:0] d);
    return ^d;
  endfunction
endpackage

// File: rtl/nibble_uart_tx_bit_timer.sv
// bit_timer: counts CLKS_PER_BIT cycles per serial bit and strobes on the last one
module bit_timer #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic clr_i,
  output logic bit_end_o
);
  localparam int W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [W-1:0] LAST = W'(CLKS_PER_BIT - 1);
  logic [W-1:0] cnt_q, cnt_d;
  assign bit_end_o = cnt_q == LAST;
  // wrap to zero on each bit boundary or when cleared
  always_comb cnt_d = (clr_i || bit_end_o) ? '0 : cnt_q + 1'b1;
  // counter register
  always_ff @(posedge clk) cnt_q <= cnt_d;
endmodule

// File: rtl/nibble_uart_tx.sv
// nibble_uart_tx: frames a 4-bit nibble as start, LSB-first data, optional even parity, stop
module nibble_uart_tx
  import nibble_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4,
  parameter bit PARITY_EN    = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] din,
  input  logic       din_valid,
  output logic       din_ready,
  output logic       txd,
  output logic       busy,
  output logic       done
);
  state_e     state_q, state_d;
  logic [3:0] shreg_q, shreg_d;
  logic [1:0] bit_cnt_q, bit_cnt_d;
  logic       par_q, par_d;
  logic       txd_q, txd_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       bit_end;
  logic       accept;
  assign din_ready = (state_q == IDLE) && !rst;
  assign accept    = din_valid && din_ready;
  assign txd       = txd_q;
  assign busy      = busy_q;
  assign done      = done_q;
  // baud timer idles at zero between frames so every bit starts aligned
  bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
    .clk      (clk),
    .clr_i    (rst || state_q == IDLE),
    .bit_end_o(bit_end)
  );
  // next state, datapath and registered-output values derived from the upcoming state
  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    par_d     = par_q;
    done_d    = (state_q == STOP) && bit_end;
    case (state_q)
      IDLE:   if (accept) begin
        state_d = START;
        shreg_d = din;
        par_d   = even_parity4(din);
      end
      START:  if (bit_end) state_d = DATA;
      DATA:   if (bit_end) begin
        shreg_d   = shreg_q >> 1;
        bit_cnt_d = bit_cnt_q + 2'd1;
        if (bit_cnt_q == 2'd3) state_d = PARITY_EN ? PARITY : STOP;
      end
      PARITY: if (bit_end) state_d = STOP;
      STOP:   if (bit_end) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    txd_d  = (state_d == START)  ? TXD_START :
             (state_d == DATA)   ? shreg_d[0] :
             (state_d == PARITY) ? par_d : TXD_IDLE;
    busy_d = state_d != IDLE;
  end
  // state and output registers; reset aborts any frame in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      par_q     <= 1'b0;
      txd_q     <= TXD_IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      par_q     <= par_d;
      txd_q     <= txd_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end
endmodule

// File: tb/tb_nibble_uart_tx.sv
// tb_nibble_uart_tx: three configurations checked every cycle against a frame-position model
module tb_nibble_uart_tx;
  localparam int NS[3] = '{4, 4, 1};
  localparam bit PS[3] = '{1, 0, 1};
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       din_valid = 1'b1;
  logic [3:0] din = 4'h0;
  logic [2:0] txd_w, busy_w, done_w, rdy_w;
  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  logic txd_log[3][1024];
  logic busy_log[3][1024];
  logic done_log[3][1024];
  int pos[3];
  logic [3:0] nib[3];
  bit dn[3];
  always #5 clk = ~clk;
  for (genvar g = 0; g < 3; g++) begin : g_dut
    nibble_uart_tx #(.CLKS_PER_BIT(NS[g]), .PARITY_EN(PS[g])) dut (
      .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
      .din_ready(rdy_w[g]), .txd(txd_w[g]), .busy(busy_w[g]), .done(done_w[g])
    );
  end
  function automatic int frame_len(int k);
    return (6 + int'(PS[k])) * NS[k];
  endfunction
  // expected line level from position inside the frame: bit slot b = (pos-1)/N
  function automatic logic exp_txd(int k);
    int b;
    if (pos[k] == 0) return 1'b1;
    b = (pos[k] - 1) / NS[k];
    if (b == 0) return 1'b0;
    if (b <= 4) return nib[k][b-1];
    if (b == 5 && PS[k]) return ^nib[k];
    return 1'b1;
  endfunction
  always @(posedge clk) begin
    cyc++;
    for (int k = 0; k < 3; k++) begin
      if (rst) begin
        pos[k] = 0;
        dn[k] = 0;
      end else if (pos[k] == 0) begin
        dn[k] = 0;
        if (din_valid) begin
          pos[k] = 1;
          nib[k] = din;
        end
      end else if (pos[k] == frame_len(k)) begin
        pos[k] = 0;
        dn[k] = 1;
      end else begin
        pos[k]++;
      end
    end
  end
  task automatic check(string name, int k, logic got, logic want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s dut%0d cyc=%0d got=%b want=%b", name, k, cyc, got, want);
    end
  endtask
  always begin
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      if (cyc < 1024) begin
        txd_log[k][cyc] = txd_w[k];
        busy_log[k][cyc] = busy_w[k];
        done_log[k][cyc] = done_w[k];
      end
      check("txd", k, txd_w[k], exp_txd(k));
      check("busy", k, busy_w[k], pos[k] != 0);
      check("done", k, done_w[k], dn[k]);
      check("din_ready", k, rdy_w[k], pos[k] == 0 && !rst);
    end
  end
  task automatic chk_frame(string name, int k, int s, string pat);
    for (int i = 0; i < pat.len(); i++)
      check(name, k, txd_log[k][s + NS[k] * i + NS[k] / 2], pat[i] == "1");
  endtask
  task automatic send(input logic [3:0] d, output int a);
    din = d;
    din_valid = 1'b1;
    @(posedge clk);
    #2;
    a = cyc;
    din_valid = 1'b0;
  endtask
  task automatic wait_edges(int n);
    repeat (n) @(posedge clk);
    #2;
  endtask
  initial begin
    int a;
    logic any;
    wait_edges(2);
    for (int k = 0; k < 3; k++) begin
      check("rst_ready", k, rdy_w[k], 1'b0);
      check("rst_txd", k, txd_w[k], 1'b1);
      check("rst_busy", k, busy_w[k], 1'b0);
      check("rst_done", k, done_w[k], 1'b0);
    end
    rst = 1'b0;
    din_valid = 1'b0;
    #1;
    check("ready_after_rst", 0, rdy_w[0], 1'b1);
    #1;
    send(4'hA, a);
    wait_edges(35);
    chk_frame("frame_A", 0, a, "0010101");
    check("busy_first", 0, busy_log[0][a], 1'b1);
    check("busy_last", 0, busy_log[0][a+27], 1'b1);
    check("busy_after", 0, busy_log[0][a+28], 1'b0);
    check("done_early", 0, done_log[0][a+27], 1'b0);
    check("done_at_29", 0, done_log[0][a+28], 1'b1);
    check("done_width", 0, done_log[0][a+29], 1'b0);
    send(4'h7, a);
    wait_edges(35);
    chk_frame("frame_7", 0, a, "0111011");
    chk_frame("frame_7_nopar", 1, a, "011101");
    check("nopar_done_early", 1, done_log[1][a+23], 1'b0);
    check("nopar_done_at_25", 1, done_log[1][a+24], 1'b1);
    din = 4'h3;
    din_valid = 1'b1;
    @(posedge clk);
    #2;
    a = cyc;
    din = 4'hC;
    while (cyc < a + 29) wait_edges(1);
    din_valid = 1'b0;
    wait_edges(35);
    chk_frame("frame_3", 0, a, "0110001");
    check("b2b_stop", 0, txd_log[0][a+27], 1'b1);
    check("b2b_idle", 0, txd_log[0][a+28], 1'b1);
    check("b2b_done", 0, done_log[0][a+28], 1'b1);
    check("b2b_start", 0, txd_log[0][a+29], 1'b0);
    chk_frame("frame_C", 0, a + 29, "0001101");
    send(4'h5, a);
    while (cyc < a + 13) wait_edges(1);
    rst = 1'b1;
    wait_edges(1);
    rst = 1'b0;
    check("abort_txd", 0, txd_log[0][a+14], 1'b1);
    check("abort_busy", 0, busy_log[0][a+14], 1'b0);
    wait_edges(35);
    any = 1'b0;
    for (int i = a + 14; i <= a + 44; i++) any |= done_log[0][i];
    check("abort_no_done", 0, any, 1'b0);
    send(4'h9, a);
    wait_edges(35);
    chk_frame("frame_9", 0, a, "0100101");
    check("frame_9_done", 0, done_log[0][a+28], 1'b1);
    send(4'h6, a);
    for (int j = 0; j < 6; j++) begin
      din = ~din;
      din_valid = j[0];
      wait_edges(1);
    end
    din_valid = 1'b0;
    wait_edges(35);
    chk_frame("frame_6_n1", 2, a, "0011001");
    check("n1_done_at_8", 2, done_log[2][a+7], 1'b1);
    check("n1_no_accept", 2, busy_log[2][a+7], 1'b0);
    check("n1_stay_idle", 2, busy_log[2][a+8], 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
